// File: rtl/serial_demux8.sv
// Receive-side deserializer for the select-stepped serial link: steers accepted bits into
// an assembly register slot by slot and presents each completed word on a valid/ready port.
module serial_demux8 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int SEL_W    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    input  logic             i_sync,
    output logic [SEL_W-1:0] o_sel,
    output logic [WIDTH-1:0] o_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_frame_err
);

    typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_out;
    logic             r_frame_err;

    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_slot;
    logic             w_accept;
    logic             w_final;
    logic [WIDTH-1:0] w_word;

    // sync redirects the current bit to slot 0, so it never waits on the output stage
    assign w_idx       = i_sync ? '0 : r_sel;
    assign w_slot      = MSB_FIRST ? (LAST - w_idx) : w_idx;
    assign o_din_ready = (w_idx != LAST) || (r_state == EMPTY) || i_out_ready;
    assign w_accept    = i_din_valid && o_din_ready;
    assign w_final     = w_accept && (w_idx == LAST);

    always_comb begin
        w_word         = r_asm;
        w_word[w_slot] = i_din;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_final) w_state_nxt = VALID;
            VALID: if (i_out_ready && !w_final) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= EMPTY;
            r_sel       <= '0;
            r_asm       <= '0;
            r_out       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= i_sync && (r_sel != '0);
            if (w_accept) begin
                r_asm <= w_word;
                r_sel <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
            end else if (i_sync) begin
                r_sel <= '0;
            end
            if (w_final) r_out <= w_word;
        end
    end

    assign o_sel       = r_sel;
    assign o_out       = r_out;
    assign o_out_valid = (r_state == VALID);
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_demux8.sv
// Bench for serial_demux8: LSB-first and MSB-first instances share one stimulus stream and
// are compared against a bit-counting reference model every cycle.
module tb_serial_demux8;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, sync, out_ready;
    logic       rdy_l, rdy_m, val_l, val_m, ferr_l, ferr_m;
    logic [2:0] sel_l, sel_m;
    logic [7:0] out_l, out_m;

    int errors = 0;
    int checks = 0;

    // reference model: bit count within frame and two word images
    int       m_cnt;
    bit [7:0] m_acc_l, m_acc_m, m_out_l, m_out_m;
    bit       m_valid, m_ferr, m_acc_last;

    always #5 clk = ~clk;

    serial_demux8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid), .o_din_ready(rdy_l),
        .i_sync(sync), .o_sel(sel_l), .o_out(out_l), .o_out_valid(val_l),
        .i_out_ready(out_ready), .o_frame_err(ferr_l));

    serial_demux8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid), .o_din_ready(rdy_m),
        .i_sync(sync), .o_sel(sel_m), .o_out(out_m), .o_out_valid(val_m),
        .i_out_ready(out_ready), .o_frame_err(ferr_m));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return sync || (m_cnt != 7) || !m_valid || out_ready;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, " sel_l"},  32'(sel_l),  32'(m_cnt));
        chk({tag, " sel_m"},  32'(sel_m),  32'(m_cnt));
        chk({tag, " valid_l"}, 32'(val_l), 32'(m_valid));
        chk({tag, " valid_m"}, 32'(val_m), 32'(m_valid));
        chk({tag, " out_l"},  32'(out_l),  32'(m_out_l));
        chk({tag, " out_m"},  32'(out_m),  32'(m_out_m));
        chk({tag, " ferr_l"}, 32'(ferr_l), 32'(m_ferr));
        chk({tag, " ferr_m"}, 32'(ferr_m), 32'(m_ferr));
    endtask

    // one clock: drive, check combinational ready, advance model on the edge, check registers
    task automatic cycle(input bit b, input bit dv, input bit sy, input bit ordy, input string tag);
        bit acc;
        din = b; din_valid = dv; sync = sy; out_ready = ordy; rst = 1'b0;
        #1;
        chk({tag, " rdy_l"}, 32'(rdy_l), 32'(m_ready()));
        chk({tag, " rdy_m"}, 32'(rdy_m), 32'(m_ready()));
        acc = dv && m_ready();
        @(posedge clk);
        m_ferr = sy && (m_cnt != 0);
        if (sy) begin m_cnt = 0; m_acc_l = '0; m_acc_m = '0; end
        if (m_valid && ordy) m_valid = 1'b0;
        if (acc) begin
            m_acc_l[m_cnt]     = b;
            m_acc_m[7 - m_cnt] = b;
            if (m_cnt == 7) begin
                m_out_l = m_acc_l; m_out_m = m_acc_m; m_valid = 1'b1; m_cnt = 0;
            end else m_cnt++;
        end
        m_acc_last = acc;
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        m_cnt = 0; m_acc_l = '0; m_acc_m = '0; m_out_l = '0; m_out_m = '0;
        m_valid = 1'b0; m_ferr = 1'b0;
        #1;
        rst = 1'b0;
        check_regs("reset");
        chk("reset rdy", 32'(rdy_l), 32'd1);
    endtask

    // retries a bit until the DUT accepts it (bounded)
    task automatic send_bit(input bit b, input bit ordy, input string tag);
        for (int k = 0; k < 20; k++) begin
            cycle(b, 1'b1, 1'b0, ordy, tag);
            if (m_acc_last) return;
        end
        chk({tag, " accept timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send_word(input bit [7:0] w, input bit ordy, input string tag);
        for (int k = 0; k < 8; k++) send_bit(w[k], ordy, tag);
    endtask

    initial begin
        bit [7:0] w1, w2;
        do_reset();

        // LSB-first roundtrip: A7 on the LSB instance, E5 on the MSB instance
        send_word(8'hA7, 1'b1, "rt");
        chk("rt out_l", 32'(out_l), 32'hA7);
        chk("rt out_m", 32'(out_m), 32'hE5);
        chk("rt valid", 32'(val_l), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "rt drain");
        chk("rt valid 1cyc", 32'(val_l), 32'd0);

        // backpressure: word2's final bit stalls until the consumer takes word1
        w1 = 8'h3C; w2 = 8'hC5;
        send_word(w1, 1'b0, "bp1");
        for (int k = 0; k < 7; k++) send_bit(w2[k], 1'b0, "bp2");
        cycle(w2[7], 1'b1, 1'b0, 1'b0, "bp stall");
        chk("bp rdy low", 32'(rdy_l), 32'd0);
        chk("bp held", 32'(out_l), 32'(w1));
        cycle(w2[7], 1'b1, 1'b0, 1'b1, "bp release");
        chk("bp word2", 32'(out_l), 32'(w2));
        chk("bp valid", 32'(val_l), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "bp drain");

        // sync mid-frame
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b1, "sy pre");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, "sy");
        chk("sy ferr", 32'(ferr_l), 32'd1);
        chk("sy sel", 32'(sel_l), 32'd1);
        w1 = 8'h5B;
        for (int k = 1; k < 8; k++) send_bit(w1[k], 1'b1, "sy post");
        chk("sy word", 32'(out_l), 32'h5B);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "sy idle");
        chk("sy ferr gone", 32'(ferr_l), 32'd0);

        // reset mid-frame at sel=5
        for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b1, "mr pre");
        chk("mr sel5", 32'(sel_l), 32'd5);
        do_reset();
        send_word(8'h96, 1'b1, "mr post");
        chk("mr word", 32'(out_l), 32'h96);

        // random traffic with occasional sync and backpressure
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0), "rnd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
